// File: rtl/ifid_queue_pkg.sv
// ============================================================================
// ifid_queue_pkg : shared types for the fetch -> decode instruction queue
// Revision 1.0
// ============================================================================
`default_nettype none

package ifid_queue_pkg;

  // RV32I canonical NOP: addi x0, x0, 0
  localparam logic [31:0] IFID_NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } ifid_fwd;

  function automatic ifid_fwd make_fwd(input logic [31:0] pc, input logic [31:0] instr);
    ifid_fwd f;
    f.pc    = pc;
    f.instr = instr;
    return f;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ifid_queue_if.sv
// ============================================================================
// ifid_queue_if : fetch-side enqueue and decode-side dequeue handshake bundle
// Revision 1.0
// ============================================================================
`default_nettype none

interface ifid_queue_if #(
  parameter int DEPTH = 4
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic             enq_valid;
  logic [31:0]      enq_pc;
  logic [31:0]      enq_instr;
  logic             enq_ready;
  logic             flush;
  logic             deq_valid;
  logic [31:0]      deq_pc;
  logic [31:0]      deq_instr;
  logic             deq_ready;
  logic [CNT_W-1:0] count;

  modport master (
    output enq_valid, enq_pc, enq_instr, flush, deq_ready,
    input  enq_ready, deq_valid, deq_pc, deq_instr, count
  );

  modport slave (
    input  enq_valid, enq_pc, enq_instr, flush, deq_ready,
    output enq_ready, deq_valid, deq_pc, deq_instr, count
  );

endinterface

`default_nettype wire

// File: rtl/ifid_queue.sv
// ============================================================================
// ifid_queue : circular IF/ID instruction queue with flush and async reset.
// Optional empty-queue bypass selected by macro IFIDQ_BYPASS_EN.
// Revision 1.0
// ============================================================================
`default_nettype none

module ifid_queue
  import ifid_queue_pkg::*;
#(
  parameter int          DEPTH     = 4,
  parameter logic [31:0] NOP_INSTR = IFID_NOP_INSTR
) (
  input  logic          clk,
  input  logic          rst,
  ifid_queue_if.slave   q
);

  localparam int               PTR_W   = $clog2(DEPTH);
  localparam int               CNT_W   = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL    = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

  ifid_fwd          mem [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] count;

  logic    empty;
  logic    full;
  logic    stored_valid;
  logic    bypass;
  logic    enq_fire;
  logic    deq_fire;
  ifid_fwd head_fwd;

  assign empty        = (count == '0);
  assign full         = (count == FULL);
  assign stored_valid = !empty && !q.flush;

`ifdef IFIDQ_BYPASS_EN
  assign bypass = empty && q.enq_valid && !q.flush;
`else
  assign bypass = 1'b0;
`endif

  // A bypassed entry taken by decode in the same cycle never touches storage.
  assign enq_fire = q.enq_valid && !full && !q.flush && !(bypass && q.deq_ready);
  assign deq_fire = stored_valid && q.deq_ready;

  always_comb begin
    head_fwd    = make_fwd(32'h0, NOP_INSTR);
    q.deq_valid = 1'b0;
    if (stored_valid) begin
      head_fwd    = mem[head];
      q.deq_valid = 1'b1;
    end else if (bypass) begin
      head_fwd    = make_fwd(q.enq_pc, q.enq_instr);
      q.deq_valid = 1'b1;
    end
  end

  assign q.deq_pc    = head_fwd.pc;
  assign q.deq_instr = head_fwd.instr;
  assign q.enq_ready = !full;
  assign q.count     = count;

  // Storage is left uncleared; pointers and count alone define validity.
  always_ff @(posedge clk) begin
    if (enq_fire) begin
      mem[tail] <= make_fwd(q.enq_pc, q.enq_instr);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (q.flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (enq_fire) begin
        tail <= tail + PTR_ONE;
      end
      if (deq_fire) begin
        head <= head + PTR_ONE;
      end
      case ({enq_fire, deq_fire})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: doc/ifid_queue.md
IFID_QUEUE -- requirements
Module: ifid_queue

Interface
REQ-001 Parameter DEPTH, default 4, number of queue entries; SHALL be a power of two, 2..16.
REQ-002 Parameter NOP_INSTR, default 32'h00000013, instruction driven on deq_instr when the queue presents no valid entry.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst  input  1  asynchronous active-low reset.
REQ-005 enq_valid  input  1  fetch presents an instruction this cycle.
REQ-006 enq_pc  input  32  PC of the presented instruction.
REQ-007 enq_instr  input  32  presented instruction word.
REQ-008 enq_ready  output  1  queue accepts an enqueue this cycle.
REQ-009 flush  input  1  redirect (taken branch/jump) discards all queued entries.
REQ-010 deq_valid  output  1  head entry valid for decode.
REQ-011 deq_pc  output  32  head entry PC.
REQ-012 deq_instr  output  32  head entry instruction, or NOP_INSTR when deq_valid=0.
REQ-013 deq_ready  input  1  decode consumes the head this cycle (decode not stalled).
REQ-014 count  output  $clog2(DEPTH)+1  registered occupancy.

Function
REQ-015 Enqueue fires when enq_valid && enq_ready && !flush; entry written at tail; tail increments modulo DEPTH.
REQ-016 enq_ready SHALL equal (count != DEPTH); it does not depend on deq_ready in the same cycle.
REQ-017 Dequeue fires when deq_valid && deq_ready; head increments modulo DEPTH.
REQ-018 deq_valid SHALL be (count != 0) && !flush, except as extended by REQ-031.
REQ-019 Simultaneous enqueue and dequeue leave count unchanged; enqueue-only increments by 1; dequeue-only decrements by 1.
REQ-020 Pointer wrap: head/tail SHALL wrap from DEPTH-1 to 0 with no entry loss or duplication.
REQ-021 Flush: on the next edge head, tail and count SHALL be 0; any enqueue in the flush cycle is dropped; no dequeue fires in the flush cycle.
REQ-022 Order: entries SHALL leave in exactly the order they were accepted.
REQ-023 deq_pc/deq_instr SHALL be stable while deq_valid=1 and deq_ready=0.
REQ-024 Minimum latency (macro off): an entry accepted at edge N is visible on deq_* in the cycle after edge N.
REQ-025 No enqueue is accepted when full, even if a dequeue fires in the same cycle.

Reset
REQ-026 Assertion of rst SHALL immediately clear head, tail and count to 0, independent of clk.
REQ-027 During reset and after release: enq_ready=1, deq_valid=0, deq_instr=NOP_INSTR, deq_pc=0, count=0.
REQ-028 Reset mid-operation discards all entries; storage contents need not be cleared.
REQ-029 Deassertion of rst is synchronous to clk; the first enqueue is accepted in the first cycle after release.

Configuration
REQ-030 Macro IFIDQ_BYPASS_EN selects the empty-queue bypass.
REQ-031 With IFIDQ_BYPASS_EN defined: when count=0, enq_valid=1 and flush=0, deq_valid=1 and deq_pc/deq_instr equal enq_pc/enq_instr combinationally; if deq_ready=1 the entry is consumed and not stored (count stays 0); if deq_ready=0 it is stored per REQ-015.
REQ-032 Without the macro: no combinational path from enq_* to deq_*; behaviour per REQ-024.

Structure
REQ-033 NOP_INSTR value and the ifid_fwd struct (pc, instr) SHALL live in the shared types package; deq_pc/deq_instr map onto ifid_fwd.
REQ-034 No sub-module; storage array, pointers and counter are inline.

Verification
REQ-035 Reset release, no enqueue -> deq_valid=0, deq_instr=32'h00000013, enq_ready=1, count=0.
REQ-036 Enqueue PCs 0x40000000,0x40000004,0x40000008,0x4000000C with deq_ready=0 -> count=4, enq_ready=0; fifth enq_valid not accepted; then deq_ready=1 -> four dequeues in order, count returns to 0.
REQ-037 Full queue, enq_valid=1 and deq_ready=1 in same cycle -> only the dequeue fires, count=3.
REQ-038 count=3, flush=1 with enq_valid=1 -> deq_valid=0 that cycle, next cycle count=0, enqueued PC absent from later output.
REQ-039 Stream 10 instructions at full rate with deq_ready=1 -> pointer wrap exercised, all 10 out in order, no duplicates; with IFIDQ_BYPASS_EN, each appears the same cycle with count=0 throughout.
REQ-040 Assert rst asynchronously mid-cycle with count=2 -> count=0 and deq_valid=0 before the next clk edge.
